// File: rtl/row_sched_pkg.sv
// Shared types for the row NIC scheduler: FSM state encoding and NIC register map.
package row_sched_pkg;

    typedef enum logic [2:0] {
        ISTAT,
        IBUF,
        RX_WAIT,
        OSTAT,
        OBUF
    } row_sched_state_e;

    localparam logic [1:0] NIC_A_IBUF  = 2'b00;
    localparam logic [1:0] NIC_A_ISTAT = 2'b01;
    localparam logic [1:0] NIC_A_OBUF  = 2'b10;
    localparam logic [1:0] NIC_A_OSTAT = 2'b11;

endpackage

// File: rtl/row_sched_tx_slots.sv
// Four single-entry pending send slots, one per node of the row.
module row_sched_tx_slots
    import row_sched_pkg::*;
#(
    parameter int PACKET_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tx_valid,
    input  logic [1:0]                   tx_node,
    input  logic [PACKET_WIDTH-1:0]      tx_data,
    input  logic                         clr,
    input  logic [1:0]                   clr_node,
    output logic [3:0]                   pend_v,
    output logic [3:0][PACKET_WIDTH-1:0] pend_d,
    output logic                         tx_ready
);

    always_comb begin
        tx_ready = !pend_v[tx_node];
    end

    // tx_ready is low for a full slot, so a fill and a clear never hit the same node
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_v <= '0;
            pend_d <= '0;
        end else begin
            if (clr) begin
                pend_v[clr_node] <= 1'b0;
            end
            if (tx_valid && tx_ready) begin
                pend_v[tx_node] <= 1'b1;
                pend_d[tx_node] <= tx_data;
            end
        end
    end

endmodule

// File: rtl/row_nic_scheduler.sv
// Round-robin owner of the four NIC register ports in a mesh row.
// Optional statistics counters: define ROW_SCHED_STATS_EN.
module row_nic_scheduler
    import row_sched_pkg::*;
#(
    parameter int PACKET_WIDTH = 64,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [7:0]                addr,
    output logic [4*PACKET_WIDTH-1:0] d_in,
    input  logic [4*PACKET_WIDTH-1:0] d_out,
    output logic [3:0]                nicEn,
    output logic [3:0]                nicEnWR,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [1:0]                tx_node,
    input  logic [PACKET_WIDTH-1:0]   tx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [1:0]                rx_node,
    output logic [PACKET_WIDTH-1:0]   rx_data
`ifdef ROW_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]          stat_tx_total,
    output logic [CNT_W-1:0]          stat_rx_total
`endif
);

    row_sched_state_e              state, next_state;
    logic [1:0]                    cur, next_cur;
    logic [PACKET_WIDTH-1:0]       cur_lane;
    logic                          clr;
    logic [3:0]                    pend_v;
    logic [3:0][PACKET_WIDTH-1:0]  pend_d;

    row_sched_tx_slots #(
        .PACKET_WIDTH(PACKET_WIDTH)
    ) u_tx_slots (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_node  (tx_node),
        .tx_data  (tx_data),
        .clr      (clr),
        .clr_node (cur),
        .pend_v   (pend_v),
        .pend_d   (pend_d),
        .tx_ready (tx_ready)
    );

    always_comb begin
        cur_lane   = d_out[cur*PACKET_WIDTH +: PACKET_WIDTH];
        next_state = state;
        next_cur   = cur;
        nicEn      = '0;
        nicEnWR    = '0;
        addr       = '0;
        d_in       = '0;
        clr        = 1'b0;
        // bus outputs are forced idle throughout the reset cycle
        if (!reset) begin
            unique case (state)
                ISTAT: begin
                    nicEn[cur]              = 1'b1;
                    addr[{cur, 1'b0} +: 2]  = NIC_A_ISTAT;
                    if (cur_lane[0]) begin
                        next_state = IBUF;
                    end else if (pend_v[cur]) begin
                        next_state = OSTAT;
                    end else begin
                        next_cur   = cur + 2'd1;
                        next_state = ISTAT;
                    end
                end
                IBUF: begin
                    nicEn[cur]              = 1'b1;
                    addr[{cur, 1'b0} +: 2]  = NIC_A_IBUF;
                    next_state              = RX_WAIT;
                end
                RX_WAIT: begin
                    if (rx_valid && rx_ready) begin
                        if (pend_v[cur]) begin
                            next_state = OSTAT;
                        end else begin
                            next_cur   = cur + 2'd1;
                            next_state = ISTAT;
                        end
                    end
                end
                OSTAT: begin
                    nicEn[cur]              = 1'b1;
                    addr[{cur, 1'b0} +: 2]  = NIC_A_OSTAT;
                    if (cur_lane[0]) begin
                        next_cur   = cur + 2'd1;
                        next_state = ISTAT;
                    end else begin
                        next_state = OBUF;
                    end
                end
                OBUF: begin
                    nicEn[cur]                             = 1'b1;
                    nicEnWR[cur]                           = 1'b1;
                    addr[{cur, 1'b0} +: 2]                 = NIC_A_OBUF;
                    d_in[cur*PACKET_WIDTH +: PACKET_WIDTH] = pend_d[cur];
                    clr                                    = 1'b1;
                    next_cur                               = cur + 2'd1;
                    next_state                             = ISTAT;
                end
                default: begin
                    next_state = ISTAT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ISTAT;
            cur   <= '0;
        end else begin
            state <= next_state;
            cur   <= next_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid <= 1'b0;
            rx_node  <= '0;
            rx_data  <= '0;
        end else if (state == IBUF) begin
            rx_valid <= 1'b1;
            rx_node  <= cur;
            rx_data  <= cur_lane;
        end else if (state == RX_WAIT && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef ROW_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_tx_total <= '0;
            stat_rx_total <= '0;
        end else begin
            if (state == OBUF) begin
                stat_tx_total <= stat_tx_total + CNT_W'(1);
            end
            if (state == IBUF) begin
                stat_rx_total <= stat_rx_total + CNT_W'(1);
            end
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_row_nic_scheduler.sv
// Self-checking bench: bench-side NIC models plus a transaction scoreboard for row_nic_scheduler.
module tb_row_nic_scheduler;

    localparam int PW = 64;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      addr;
    logic [4*PW-1:0] d_in;
    logic [4*PW-1:0] d_out;
    logic [3:0]      nicEn;
    logic [3:0]      nicEnWR;
    logic            tx_valid;
    logic            tx_ready;
    logic [1:0]      tx_node;
    logic [PW-1:0]   tx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [1:0]      rx_node;
    logic [PW-1:0]   rx_data;
`ifdef ROW_SCHED_STATS_EN
    logic [CW-1:0]   stat_tx_total;
    logic [CW-1:0]   stat_rx_total;
`endif

    always #5 clk = ~clk;

    row_nic_scheduler #(
        .PACKET_WIDTH(PW),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .d_in     (d_in),
        .d_out    (d_out),
        .nicEn    (nicEn),
        .nicEnWR  (nicEnWR),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_node  (tx_node),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_node  (rx_node),
        .rx_data  (rx_data)
`ifdef ROW_SCHED_STATS_EN
        ,
        .stat_tx_total (stat_tx_total),
        .stat_rx_total (stat_rx_total)
`endif
    );

    // NIC models and scoreboard state
    logic          in_full  [4];
    logic [PW-1:0] in_data  [4];
    logic          out_full [4];
    logic          exp_pend_v [4];
    logic [PW-1:0] exp_pend_d [4];
    logic          exp_rx_pending;
    logic [1:0]    exp_rx_node;
    logic [PW-1:0] exp_rx_data;
    int            last_istat;
    int            expect_ibuf;
    logic          prev_stall;
    logic [1:0]    prev_rx_node;
    logic [PW-1:0] prev_rx_data;
    int            cnt_tx, cnt_rx;
    bit            rand_en;
    int            n_checks, n_errors;

    // sampled DUT view for the current cycle
    logic            s_reset;
    logic [3:0]      s_nic_en, s_nic_en_wr;
    logic [7:0]      s_addr;
    logic [4*PW-1:0] s_d_in;
    logic            s_tx_valid, s_tx_ready, s_rx_valid, s_rx_ready;
    logic [1:0]      s_tx_node, s_rx_node;
    logic [PW-1:0]   s_tx_data, s_rx_data;
    int              s_an;
    logic [1:0]      s_code;
    bit              is_istat, is_ibuf, is_write;

    always_comb begin
        d_out = '0;
        for (int n = 0; n < 4; n++) begin
            if (nicEn[n]) begin
                case (addr[2*n +: 2])
                    2'b00:   d_out[n*PW +: PW] = in_data[n];
                    2'b01:   d_out[n*PW +: PW] = {{(PW-1){1'b0}}, in_full[n]};
                    2'b11:   d_out[n*PW +: PW] = {{(PW-1){1'b0}}, out_full[n]};
                    default: d_out[n*PW +: PW] = '0;
                endcase
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic int acc_idx(input logic [3:0] en);
        for (int i = 0; i < 4; i++) begin
            if (en[i]) return i;
        end
        return -1;
    endfunction

    task automatic clear_model();
        for (int n = 0; n < 4; n++) exp_pend_v[n] = 1'b0;
        exp_rx_pending = 1'b0;
        last_istat     = 3;
        expect_ibuf    = -1;
        prev_stall     = 1'b0;
        cnt_tx         = 0;
        cnt_rx         = 0;
    endtask

    // one clock: sample and check at negedge, apply NIC/model effects just after posedge
    task automatic cycle();
        logic [4*PW-1:0] mask;
        @(negedge clk);
        s_reset     = reset;
        s_nic_en    = nicEn;
        s_nic_en_wr = nicEnWR;
        s_addr      = addr;
        s_d_in      = d_in;
        s_tx_valid  = tx_valid;
        s_tx_ready  = tx_ready;
        s_tx_node   = tx_node;
        s_tx_data   = tx_data;
        s_rx_valid  = rx_valid;
        s_rx_ready  = rx_ready;
        s_rx_node   = rx_node;
        s_rx_data   = rx_data;
        s_an        = acc_idx(s_nic_en);
        s_code      = (s_an >= 0) ? s_addr[2*s_an +: 2] : 2'b00;
        is_istat    = (s_an >= 0) && !s_nic_en_wr[s_an] && s_code == 2'b01;
        is_ibuf     = (s_an >= 0) && !s_nic_en_wr[s_an] && s_code == 2'b00;
        is_write    = (s_an >= 0) && s_nic_en_wr[s_an];
        if (!s_reset) begin
            check_val("bus_onehot", 64'($countones(s_nic_en) <= 1), 64'd1);
            check_val("wr_without_en", 64'(s_nic_en_wr & ~s_nic_en), 64'd0);
            if (is_write) check_val("wr_addr", 64'(s_code), 64'd2);
            mask = '0;
            if (is_write) mask[s_an*PW +: PW] = '1;
            check_val("d_in_idle_lanes", 64'((s_d_in & ~mask) != '0), 64'd0);
            if (s_rx_valid) check_val("bus_quiet_rx_wait", 64'(s_nic_en), 64'd0);
            if (prev_stall) begin
                check_val("rx_hold_valid", 64'(s_rx_valid), 64'd1);
                check_val("rx_hold_node", 64'(s_rx_node), 64'(prev_rx_node));
                check_val("rx_hold_data", s_rx_data, prev_rx_data);
            end
            check_val("tx_ready", 64'(s_tx_ready), 64'(!exp_pend_v[s_tx_node]));
            if (is_istat) check_val("istat_order", 64'(s_an), 64'((last_istat + 1) % 4));
            if (expect_ibuf >= 0)
                check_val("ibuf_after_full", 64'(is_ibuf && s_an == expect_ibuf), 64'd1);
            else
                check_val("ibuf_unexpected", 64'(is_ibuf), 64'd0);
            if (s_rx_valid && s_rx_ready) begin
                check_val("rx_expected", 64'(exp_rx_pending), 64'd1);
                check_val("rx_node", 64'(s_rx_node), 64'(exp_rx_node));
                check_val("rx_data", s_rx_data, exp_rx_data);
            end
            if (is_write) begin
                check_val("wr_slot_pending", 64'(exp_pend_v[s_an]), 64'd1);
                check_val("wr_data", s_d_in[s_an*PW +: PW], exp_pend_d[s_an]);
                check_val("wr_out_not_full", 64'(out_full[s_an]), 64'd0);
            end
        end
        @(posedge clk);
        #1;
        if (s_reset) begin
            clear_model();
        end else begin
            expect_ibuf = -1;
            if (is_istat) begin
                last_istat = s_an;
                if (in_full[s_an]) expect_ibuf = s_an;
            end
            if (is_ibuf) begin
                exp_rx_pending  = 1'b1;
                exp_rx_node     = 2'(s_an);
                exp_rx_data     = in_data[s_an];
                in_full[s_an]   = 1'b0;
                cnt_rx++;
            end
            if (s_rx_valid && s_rx_ready) exp_rx_pending = 1'b0;
            if (is_write) begin
                exp_pend_v[s_an] = 1'b0;
                out_full[s_an]   = 1'b1;
                cnt_tx++;
            end
            if (s_tx_valid && s_tx_ready) begin
                exp_pend_v[s_tx_node] = 1'b1;
                exp_pend_d[s_tx_node] = s_tx_data;
            end
            prev_stall   = s_rx_valid && !s_rx_ready;
            prev_rx_node = s_rx_node;
            prev_rx_data = s_rx_data;
        end
        if (rand_en) begin
            tx_valid = ($urandom % 3) != 0;
            tx_node  = 2'($urandom % 4);
            tx_data  = {$urandom, $urandom};
            rx_ready = ($urandom % 4) != 0;
            for (int n = 0; n < 4; n++) begin
                if (!in_full[n] && ($urandom % 6) == 0) begin
                    in_full[n] = 1'b1;
                    in_data[n] = {$urandom, $urandom};
                end
                if (out_full[n] && ($urandom % 3) == 0) out_full[n] = 1'b0;
            end
        end
    endtask

    task automatic wait_acc(input int node, input logic [1:0] code, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle();
            if (s_an == node && !s_nic_en_wr[node] && s_code == code) found = 1'b1;
        end
        check_val("wait_access", 64'(found), 64'd1);
    endtask

    initial begin
        logic [4*PW-1:0] exp_d_in;
        logic [PW-1:0]   data_a, data_bp;
        bit              found;

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_node  = '0;
        tx_data  = '0;
        rx_ready = 1'b1;
        rand_en  = 1'b0;
        n_checks = 0;
        n_errors = 0;
        for (int n = 0; n < 4; n++) begin
            in_full[n]    = 1'b0;
            in_data[n]    = '0;
            out_full[n]   = 1'b0;
            exp_pend_d[n] = '0;
        end
        clear_model();

        // reset state
        cycle();
        cycle();
        check_val("rst_nicEn", 64'(s_nic_en), 64'd0);
        check_val("rst_nicEnWR", 64'(s_nic_en_wr), 64'd0);
        check_val("rst_addr", 64'(s_addr), 64'd0);
        check_val("rst_d_in", 64'(s_d_in != '0), 64'd0);
        check_val("rst_rx_valid", 64'(s_rx_valid), 64'd0);
        check_val("rst_rx_node", 64'(s_rx_node), 64'd0);
        check_val("rst_rx_data", s_rx_data, 64'd0);
        reset = 1'b0;

        // idle sweep
        for (int k = 0; k < 8; k++) begin
            cycle();
            check_val("idle_nicEn", 64'(s_nic_en), 64'(4'b0001 << (k % 4)));
            check_val("idle_addr", 64'(s_addr), 64'(8'b01 << (2 * (k % 4))));
        end

        // single receive from node 2
        in_full[2] = 1'b1;
        in_data[2] = 64'hDEAD_BEEF_0000_0002;
        wait_acc(2, 2'b01, 8);
        cycle();
        check_val("rx1_ibuf_en", 64'(s_nic_en), 64'b0100);
        check_val("rx1_ibuf_addr", 64'(s_addr), 64'd0);
        cycle();
        check_val("rx1_valid", 64'(s_rx_valid), 64'd1);
        check_val("rx1_node", 64'(s_rx_node), 64'd2);
        check_val("rx1_data", s_rx_data, 64'hDEAD_BEEF_0000_0002);
        cycle();
        check_val("rx1_next_node", 64'(s_nic_en), 64'b1000);

        // back-pressure on node 0
        data_bp    = 64'hA5A5_0000_1234_0000;
        in_full[0] = 1'b1;
        in_data[0] = data_bp;
        rx_ready   = 1'b0;
        wait_acc(0, 2'b01, 8);
        cycle();
        for (int k = 0; k < 10; k++) begin
            cycle();
            check_val("bp_valid", 64'(s_rx_valid), 64'd1);
            check_val("bp_data", s_rx_data, data_bp);
            check_val("bp_bus_idle", 64'(s_nic_en | s_nic_en_wr), 64'd0);
        end
        rx_ready = 1'b1;
        cycle();
        cycle();
        check_val("bp_resume_en", 64'(s_nic_en), 64'b0010);
        check_val("bp_resume_addr", 64'(s_addr), 64'b0000_0100);

        // send to node 1
        tx_valid = 1'b1;
        tx_node  = 2'd1;
        tx_data  = 64'h0123_4567_89AB_CDEF;
        cycle();
        check_val("tx1_accept", 64'(s_tx_ready), 64'd1);
        tx_valid = 1'b0;
        wait_acc(1, 2'b01, 8);
        cycle();
        check_val("tx1_ostat_en", 64'(s_nic_en), 64'b0010);
        check_val("tx1_ostat_addr", 64'(s_addr), 64'b0000_1100);
        cycle();
        exp_d_in = '0;
        exp_d_in[PW +: PW] = 64'h0123_4567_89AB_CDEF;
        check_val("tx1_obuf_wr", 64'(s_nic_en_wr), 64'b0010);
        check_val("tx1_obuf_addr", 64'(s_addr), 64'b0000_1000);
        check_val("tx1_obuf_d_in", 64'(s_d_in == exp_d_in), 64'd1);
        check_val("tx1_busy", 64'(s_tx_ready), 64'd0);
        cycle();
        check_val("tx1_free", 64'(s_tx_ready), 64'd1);

        // output full on node 0, slot blocking
        data_a      = 64'h0000_AAAA_5555_0000;
        out_full[0] = 1'b1;
        tx_valid    = 1'b1;
        tx_node     = 2'd0;
        tx_data     = data_a;
        cycle();
        check_val("blk_first_accept", 64'(s_tx_ready), 64'd1);
        tx_data = 64'h0000_BBBB_0000_0000;
        cycle();
        check_val("blk_second_stall", 64'(s_tx_ready), 64'd0);
        tx_node = 2'd3;
        tx_data = 64'h0000_CCCC_0000_0003;
        cycle();
        check_val("blk_other_accept", 64'(s_tx_ready), 64'd1);
        tx_valid = 1'b0;
        wait_acc(0, 2'b11, 24);
        cycle();
        check_val("blk_no_write", 64'(s_nic_en_wr), 64'd0);
        check_val("blk_advance", 64'(s_nic_en), 64'b0010);
        wait_acc(0, 2'b11, 24);
        out_full[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (s_nic_en_wr == 4'b0001) found = 1'b1;
        end
        check_val("blk_retry_write", 64'(found), 64'd1);
        check_val("blk_retry_data", s_d_in[0 +: PW], data_a);

        // reset while waiting on the receive sink
        in_full[1] = 1'b1;
        in_data[1] = 64'h1111_2222_3333_4444;
        rx_ready   = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (s_rx_valid) found = 1'b1;
        end
        check_val("mr_reach_rx_wait", 64'(found), 64'd1);
        tx_valid = 1'b1;
        tx_node  = 2'd2;
        tx_data  = 64'h0000_DDDD_0000_0002;
        cycle();
        check_val("mr_tx_accept", 64'(s_tx_ready), 64'd1);
        tx_valid = 1'b0;
        reset    = 1'b1;
        cycle();
        check_val("mr_bus_idle", 64'(s_nic_en | s_nic_en_wr), 64'd0);
        check_val("mr_d_in_idle", 64'(s_d_in != '0), 64'd0);
        reset    = 1'b0;
        rx_ready = 1'b1;
        cycle();
        check_val("mr_rx_valid", 64'(s_rx_valid), 64'd0);
        check_val("mr_istat0_en", 64'(s_nic_en), 64'b0001);
        check_val("mr_istat0_addr", 64'(s_addr), 64'b0000_0001);
        check_val("mr_slot_cleared", 64'(s_tx_ready), 64'd1);

        // randomized traffic against the scoreboard
        rand_en = 1'b1;
        for (int k = 0; k < 4000; k++) cycle();
        rand_en  = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            for (int n = 0; n < 4; n++) out_full[n] = 1'b0;
            cycle();
            found = !exp_rx_pending && !rx_valid;
            for (int n = 0; n < 4; n++) begin
                if (exp_pend_v[n] || in_full[n]) found = 1'b0;
            end
        end
        check_val("drain_complete", 64'(found), 64'd1);

`ifdef ROW_SCHED_STATS_EN
        cycle();
        check_val("stat_tx_total", 64'(stat_tx_total), 64'(cnt_tx[CW-1:0]));
        check_val("stat_rx_total", 64'(stat_rx_total), 64'(cnt_rx[CW-1:0]));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/row_nic_scheduler.md
# row_nic_scheduler

Sequencer that owns the CPU-side register interface of the four NICs in one mesh row, in place of four independent CPU testbench drivers. It polls each NIC round-robin. It drains full input buffers onto a single receive stream and injects packets from a single send stream into the addressed node's output buffer. It performs at most one NIC register access per cycle and sits between a row-level traffic source/sink and the row's `nic` instances.

## Interface
- `PACKET_WIDTH`, 64, NIC packet width in bits.
- `CNT_W`, 16, statistics counter width (used only with the macro enabled).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `addr` out 8: NIC register address, `{node3, node2, node1, node0}`, 2 bits each.
- `d_in` out 4×PACKET_WIDTH: NIC write data, node n at bits `[n*PACKET_WIDTH +: PACKET_WIDTH]`.
- `d_out` in 4×PACKET_WIDTH: NIC read data, same packing.
- `nicEn` out 4: per-node access enable.
- `nicEnWR` out 4: per-node write enable.
- `tx_valid` in 1: send request.
- `tx_ready` out 1: send accept.
- `tx_node` in 2: target node index for the send.
- `tx_data` in PACKET_WIDTH: send packet.
- `rx_valid` out 1: received packet available.
- `rx_ready` in 1: sink accepts the received packet.
- `rx_node` out 2: node the received packet came from.
- `rx_data` out PACKET_WIDTH: received packet.
- `stat_tx_total` out CNT_W: packets written to NICs (`ROW_SCHED_STATS_EN` only).
- `stat_rx_total` out CNT_W: packets read from NICs (`ROW_SCHED_STATS_EN` only).

## Operation
- **NIC register map:**
  - 00: input buffer (read).
  - 01: input status, `d_out[0]=1` means full.
  - 10: output buffer (write).
  - 11: output status, `d_out[0]=1` means full.
- **NIC access semantics:** read data is combinational, valid in the cycle `nicEn=1`. A read of 00 empties the NIC input buffer at that edge. A write of 10 fills the output buffer at that edge.
- **Bus discipline:** exactly one `nicEn` bit is high during ISTAT/IBUF/OSTAT/OBUF. All `nicEn`/`nicEnWR` bits are 0 in RX_WAIT. `d_in` lanes are 0 unless being written.
- **Pending send slots:** one per node, `pend_v[3:0]` / `pend_d[3:0]`.
  - `tx_ready = !pend_v[tx_node]`, combinational.
  - A handshake (`tx_valid & tx_ready`) sets the slot at the edge.
  - A request to a node with a full slot is stalled, even if other slots are free.
- **Pointer:** `cur` (2 bits); "advance" means `cur ← cur+1` (3 wraps to 0), then go to ISTAT.
- **FSM states:**
  - **ISTAT:** read 01 of `cur`. If full → IBUF; else if `pend_v[cur]` → OSTAT; else advance.
  - **IBUF:** read 00. Capture `d_out` into `rx_data`, set `rx_node=cur`, set `rx_valid=1` at the edge → RX_WAIT.
  - **RX_WAIT:** hold `rx_*` stable while `!rx_ready`. On `rx_valid & rx_ready`, clear `rx_valid`; then → OSTAT if `pend_v[cur]`, else advance.
  - **OSTAT:** read 11. If full → advance; the slot is kept and retried on the next visit. Else → OBUF.
  - **OBUF:** write `pend_d[cur]` to 10 (`nicEn[cur]=nicEnWR[cur]=1`). Clear `pend_v[cur]` at the edge; advance.
- **Fairness:** at most one receive and one send per node per visit.
- **Simultaneous events:** a tx handshake to `cur` during ISTAT/RX_WAIT is seen by the next-state decision only from the following cycle. A tx handshake in the same cycle that OBUF clears that slot is impossible, because `tx_ready` for that node is 0.
- **Reset:** `cur=0`, state ISTAT, `pend_v=0`, `rx_valid=0`, `rx_node=0`, `rx_data=0`, all `nicEn`/`nicEnWR`/`addr`/`d_in` = 0 in the reset cycle, stat counters 0. A packet in flight at reset is discarded.

## Timing
- **Idle sweep:** 1 cycle per node, 4 cycles per full round.
- **Receive latency:** ISTAT hit at cycle t → IBUF at t+1 → `rx_valid` high at t+2.
- **Send latency:** slot written at edge e, ISTAT of that node at cycle c ≥ e → OSTAT at c+1 → OBUF at c+2. Slot is free (`tx_ready` high) at c+3.
- **Worst-case round:** 4 nodes × 5 cycles = 20 cycles, plus `rx_ready` stalls.
- The outputs `nicEn`, `nicEnWR`, `addr`, `d_in` are decoded combinationally from the registered state and `cur`.

## Configuration
- **`ROW_SCHED_STATS_EN` defined:** `stat_tx_total` increments on every OBUF cycle; `stat_rx_total` increments on every IBUF cycle. Both wrap modulo 2^CNT_W and reset to 0.
- **`ROW_SCHED_STATS_EN` undefined:** the counters and their ports are absent. All other behaviour is identical.

## Structure
- **Package `row_sched_pkg`:** the state enum (ISTAT, IBUF, RX_WAIT, OSTAT, OBUF) and the register-address constants `NIC_A_IBUF`, `NIC_A_ISTAT`, `NIC_A_OBUF`, `NIC_A_OSTAT`.
- **Sub-module `row_sched_tx_slots`:** the four pending send slots. Inputs are the tx handshake and the clear request; outputs are `pend_v`, `pend_d`, and `tx_ready`.

## Test plan
- **Idle:** no traffic, all statuses 0 → `nicEn` cycles 0001, 0010, 0100, 1000, 0001…, each with addr 01, one node per cycle.
- **Single receive:** node 2 ISTAT returns 1, IBUF returns 0xDEAD_BEEF_0000_0002, `rx_ready=1` → `rx_valid` 2 cycles after the ISTAT with `rx_node=2` and that data; next access is to node 3.
- **Back-pressure:** hold `rx_ready=0` for 10 cycles → `rx_*` stable, all `nicEn`=0 throughout; on release, the scheduler resumes with node+1.
- **Send:** tx to node 1 with 0x0123_4567_89AB_CDEF, OSTAT returns 0 → OBUF writes the data on `d_in` lane 1 with `nicEnWR=0010`; `tx_ready` for node 1 returns high the next cycle.
- **Output full and slot blocking:** node 0 OSTAT returns 1 → no write, scheduler advances; a second tx to node 0 is stalled, while a tx to node 3 is accepted.
- **Reset mid-operation:** reset asserted during RX_WAIT → next cycle `rx_valid=0`, `pend_v=0`, ISTAT at node 0.
